// File: rtl/axi_burst_ram.sv
// AXI-style burst RAM slave: independent read and write engines over one word-addressed memory.
// Supports FIXED/INCR/WRAP bursts, byte strobes, IDs and per-beat range checking.
module axi_burst_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 1024,
    parameter int ID_WIDTH   = 4
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic                    RAM_EN,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [ID_WIDTH-1:0]     AWID,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic [7:0]              AWLEN,
    input  logic [1:0]              AWBURST,
    input  logic                    WVALID,
    output logic                    WREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WLAST,
    output logic                    BVALID,
    input  logic                    BREADY,
    output logic [ID_WIDTH-1:0]     BID,
    output logic [1:0]              BRESP,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    input  logic [ID_WIDTH-1:0]     ARID,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic [7:0]              ARLEN,
    input  logic [1:0]              ARBURST,
    output logic                    RVALID,
    input  logic                    RREADY,
    output logic [ID_WIDTH-1:0]     RID,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RLAST
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_WIDTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0]   DEPTH_LIMIT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE    = ADDR_WIDTH'(1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wstate_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_e;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    function automatic logic [ADDR_WIDTH-1:0] next_addr(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [7:0]            len,
        input logic [1:0]            burst
    );
        logic [ADDR_WIDTH-1:0] inc;
        logic [ADDR_WIDTH-1:0] mask;
        inc  = addr + ADDR_ONE;
        // Legal wrap lengths are 2/4/8/16 beats, so LEN itself is the wrap mask.
        mask = ADDR_WIDTH'(len[3:0]);
        case (burst)
            2'b00:   next_addr = addr;
            2'b10:   next_addr = (addr & ~mask) | (inc & mask);
            default: next_addr = inc;
        endcase
    endfunction

    function automatic logic burst_bad(input logic [7:0] len, input logic [1:0] burst);
        burst_bad = (burst == 2'b11) ||
                    ((burst == 2'b10) && !((len == 8'd1) || (len == 8'd3) ||
                                           (len == 8'd7) || (len == 8'd15)));
    endfunction

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
        in_range = {1'b0, addr} < DEPTH_LIMIT;
    endfunction

    wstate_e               wstate_q, wstate_d;
    logic [ID_WIDTH-1:0]   w_id_q, w_id_d;
    logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
    logic [7:0]            w_len_q, w_len_d;
    logic [1:0]            w_burst_q, w_burst_d;
    logic [7:0]            w_beat_q, w_beat_d;
    logic                  w_bad_q, w_bad_d;
    logic                  w_err_q, w_err_d;
    logic [1:0]            w_bresp_q, w_bresp_d;

    rstate_e               rstate_q, rstate_d;
    logic [ID_WIDTH-1:0]   r_id_q, r_id_d;
    logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
    logic [7:0]            r_len_q, r_len_d;
    logic [1:0]            r_burst_q, r_burst_d;
    logic [7:0]            r_beat_q, r_beat_d;
    logic                  r_bad_q, r_bad_d;
    logic                  r_beat_err_q, r_beat_err_d;
    logic                  r_last_q, r_last_d;

    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  mem_we;
    logic [IDX_WIDTH-1:0]  w_idx;
    logic                  w_last_beat;
    logic                  w_beat_err;
    logic                  rd_en;
    logic [IDX_WIDTH-1:0]  rd_idx;
    logic [ADDR_WIDTH-1:0] r_next;
    logic                  rvalid_int;

    assign AWREADY = RAM_EN && (wstate_q == W_IDLE) && ARESETn;
    assign ARREADY = RAM_EN && (rstate_q == R_IDLE) && ARESETn;

    always_comb begin
        wstate_d    = wstate_q;
        w_id_d      = w_id_q;
        w_addr_d    = w_addr_q;
        w_len_d     = w_len_q;
        w_burst_d   = w_burst_q;
        w_beat_d    = w_beat_q;
        w_bad_d     = w_bad_q;
        w_err_d     = w_err_q;
        w_bresp_d   = w_bresp_q;
        mem_we      = 1'b0;
        w_idx       = w_addr_q[IDX_WIDTH-1:0];
        w_last_beat = (w_beat_q == w_len_q);
        w_beat_err  = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                if (AWVALID && AWREADY) begin
                    w_id_d    = AWID;
                    w_addr_d  = AWADDR;
                    w_len_d   = AWLEN;
                    w_burst_d = AWBURST;
                    w_beat_d  = 8'd0;
                    w_bad_d   = burst_bad(AWLEN, AWBURST);
                    w_err_d   = 1'b0;
                    wstate_d  = W_DATA;
                end
            end
            W_DATA: begin
                if (WVALID) begin
                    // Beat count ends the burst; a misplaced WLAST only flags the response.
                    w_beat_err = w_bad_q || !in_range(w_addr_q) || (WLAST != w_last_beat);
                    mem_we     = ARESETn && !w_bad_q && in_range(w_addr_q);
                    w_addr_d   = next_addr(w_addr_q, w_len_q, w_burst_q);
                    w_beat_d   = w_beat_q + 8'd1;
                    w_err_d    = w_err_q || w_beat_err;
                    if (w_last_beat) begin
                        wstate_d  = W_RESP;
                        w_bresp_d = (w_err_q || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                    end
                end
            end
            W_RESP: begin
                if (BREADY) begin
                    wstate_d = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_comb begin
        rstate_d     = rstate_q;
        r_id_d       = r_id_q;
        r_addr_d     = r_addr_q;
        r_len_d      = r_len_q;
        r_burst_d    = r_burst_q;
        r_beat_d     = r_beat_q;
        r_bad_d      = r_bad_q;
        r_beat_err_d = r_beat_err_q;
        r_last_d     = r_last_q;
        rd_en        = 1'b0;
        rd_idx       = r_addr_q[IDX_WIDTH-1:0];
        r_next       = next_addr(r_addr_q, r_len_q, r_burst_q);
        if (rstate_q == R_IDLE) begin
            if (ARVALID && ARREADY) begin
                // Fetch the first word on the handshake edge so beat 0 is valid next cycle.
                rd_en        = 1'b1;
                rd_idx       = ARADDR[IDX_WIDTH-1:0];
                r_id_d       = ARID;
                r_addr_d     = ARADDR;
                r_len_d      = ARLEN;
                r_burst_d    = ARBURST;
                r_beat_d     = 8'd0;
                r_bad_d      = burst_bad(ARLEN, ARBURST);
                r_beat_err_d = burst_bad(ARLEN, ARBURST) || !in_range(ARADDR);
                r_last_d     = (ARLEN == 8'd0);
                rstate_d     = R_DATA;
            end
        end else begin
            if (RREADY) begin
                if (r_last_q) begin
                    rstate_d = R_IDLE;
                    r_last_d = 1'b0;
                end else begin
                    rd_en        = 1'b1;
                    rd_idx       = r_next[IDX_WIDTH-1:0];
                    r_addr_d     = r_next;
                    r_beat_d     = r_beat_q + 8'd1;
                    r_last_d     = ((r_beat_q + 8'd1) == r_len_q);
                    r_beat_err_d = r_bad_q || !in_range(r_next);
                end
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            wstate_q     <= W_IDLE;
            w_id_q       <= '0;
            w_addr_q     <= '0;
            w_len_q      <= '0;
            w_burst_q    <= '0;
            w_beat_q     <= '0;
            w_bad_q      <= 1'b0;
            w_err_q      <= 1'b0;
            w_bresp_q    <= '0;
            rstate_q     <= R_IDLE;
            r_id_q       <= '0;
            r_addr_q     <= '0;
            r_len_q      <= '0;
            r_burst_q    <= '0;
            r_beat_q     <= '0;
            r_bad_q      <= 1'b0;
            r_beat_err_q <= 1'b0;
            r_last_q     <= 1'b0;
        end else begin
            wstate_q     <= wstate_d;
            w_id_q       <= w_id_d;
            w_addr_q     <= w_addr_d;
            w_len_q      <= w_len_d;
            w_burst_q    <= w_burst_d;
            w_beat_q     <= w_beat_d;
            w_bad_q      <= w_bad_d;
            w_err_q      <= w_err_d;
            w_bresp_q    <= w_bresp_d;
            rstate_q     <= rstate_d;
            r_id_q       <= r_id_d;
            r_addr_q     <= r_addr_d;
            r_len_q      <= r_len_d;
            r_burst_q    <= r_burst_d;
            r_beat_q     <= r_beat_d;
            r_bad_q      <= r_bad_d;
            r_beat_err_q <= r_beat_err_d;
            r_last_q     <= r_last_d;
        end
    end

    // Memory is never reset; a read colliding with a write returns the pre-write word.
    always_ff @(posedge ACLK) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (WSTRB[b]) begin
                    mem[w_idx][8*b +: 8] <= WDATA[8*b +: 8];
                end
            end
        end
        if (rd_en) begin
            rdata_q <= mem[rd_idx];
        end
    end

    assign rvalid_int = (rstate_q == R_DATA) && ARESETn;
    assign RVALID     = rvalid_int;
    assign RID        = ARESETn ? r_id_q : '0;
    assign RLAST      = rvalid_int && r_last_q;
    assign RRESP      = (rvalid_int && r_beat_err_q) ? RESP_SLVERR : RESP_OKAY;
    assign RDATA      = (rvalid_int && !r_beat_err_q) ? rdata_q : '0;

    assign WREADY = (wstate_q == W_DATA) && ARESETn;
    assign BVALID = (wstate_q == W_RESP) && ARESETn;
    assign BID    = ARESETn ? w_id_q : '0;
    assign BRESP  = ARESETn ? w_bresp_q : '0;

endmodule

// File: tb/tb_axi_burst_ram.sv
// Bench for axi_burst_ram: transaction table with a reference memory, R/B scoreboards,
// and hand sequences for backpressure, reset mid-burst and RAM_EN gating.
module tb_axi_burst_ram;

    localparam int DEPTH = 1024;
    localparam logic [1:0] FIX = 2'b00, INC = 2'b01, WRP = 2'b10, RSV = 2'b11;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        RAM_EN = 1'b1;
    logic        AWVALID = 1'b0, AWREADY;
    logic [3:0]  AWID = '0;
    logic [15:0] AWADDR = '0;
    logic [7:0]  AWLEN = '0;
    logic [1:0]  AWBURST = '0;
    logic        WVALID = 1'b0, WREADY;
    logic [31:0] WDATA = '0;
    logic [3:0]  WSTRB = '0;
    logic        WLAST = 1'b0;
    logic        BVALID, BREADY = 1'b0;
    logic [3:0]  BID;
    logic [1:0]  BRESP;
    logic        ARVALID = 1'b0, ARREADY;
    logic [3:0]  ARID = '0;
    logic [15:0] ARADDR = '0;
    logic [7:0]  ARLEN = '0;
    logic [1:0]  ARBURST = '0;
    logic        RVALID, RREADY = 1'b1;
    logic [3:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;

    axi_burst_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .DEPTH(DEPTH), .ID_WIDTH(4)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .RAM_EN(RAM_EN),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWID(AWID), .AWADDR(AWADDR),
        .AWLEN(AWLEN), .AWBURST(AWBURST),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
        .BVALID(BVALID), .BREADY(BREADY), .BID(BID), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARID(ARID), .ARADDR(ARADDR),
        .ARLEN(ARLEN), .ARBURST(ARBURST),
        .RVALID(RVALID), .RREADY(RREADY), .RID(RID), .RDATA(RDATA), .RRESP(RRESP),
        .RLAST(RLAST)
    );

    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic        is_wr;
        logic [3:0]  id;
        logic [15:0] addr;
        logic [7:0]  len;
        logic [1:0]  burst;
        logic [3:0]  strb;
        logic [31:0] base;
        logic        bad_wlast;
        logic [1:0]  exp_bresp;
        logic        chk_d0;
        logic [31:0] exp_d0;
    } vec_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [1:0]  resp;
        logic        last;
        logic [31:0] data;
    } rbeat_t;

    vec_t        vecs [20];
    rbeat_t      rq [$];
    logic [5:0]  bq [$];
    logic [31:0] model [0:DEPTH-1];
    int          n_vec = 0;
    int          n_fail = 0;
    logic        r_first = 1'b0;
    logic [31:0] r_d0 = '0;
    logic        rr_mode = 1'b0;
    int          rr_cnt = 0;
    logic        stall_prev = 1'b0;
    rbeat_t      held = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_vec++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, want);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_vec++;
        n_fail++;
        $display("FAIL %s: got timeout, required handshake", name);
    endtask

    function automatic vec_t mk(input logic w, input logic [3:0] id, input logic [15:0] a,
                                input logic [7:0] l, input logic [1:0] b, input logic [3:0] s,
                                input logic [31:0] base, input logic bw, input logic [1:0] er,
                                input logic [31:0] d0);
        vec_t v;
        v.is_wr = w;   v.id = id;     v.addr = a;       v.len = l;
        v.burst = b;   v.strb = s;    v.base = base;    v.bad_wlast = bw;
        v.exp_bresp = er; v.chk_d0 = !w; v.exp_d0 = d0;
        return v;
    endfunction

    function automatic logic [15:0] t_next(input logic [15:0] a, input logic [7:0] l,
                                           input logic [1:0] b);
        int size;
        int base;
        case (b)
            2'b00: return a;
            2'b10: begin
                size = int'(l) + 1;
                base = (int'(a) / size) * size;
                return 16'(base + ((int'(a) - base + 1) % size));
            end
            default: return a + 16'd1;
        endcase
    endfunction

    function automatic logic t_bad(input logic [7:0] l, input logic [1:0] b);
        return (b == 2'b11) || (b == 2'b10 && !(l == 1 || l == 3 || l == 7 || l == 15));
    endfunction

    // RREADY pattern 1,0,0 repeating in backpressure mode, constant 1 otherwise.
    always @(posedge ACLK) begin
        #1;
        if (rr_mode) begin
            rr_cnt = (rr_cnt == 2) ? 0 : rr_cnt + 1;
            RREADY = (rr_cnt == 0);
        end else begin
            rr_cnt = 0;
            RREADY = 1'b1;
        end
    end

    always @(negedge ACLK) begin
        rbeat_t cur;
        rbeat_t want;
        cur = {RID, RRESP, RLAST, RDATA};
        if (stall_prev) check("R stall hold", 64'({RVALID, cur}), 64'({1'b1, held}));
        if (RVALID && RREADY) begin
            if (rq.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL R unexpected beat: got %h required none", cur);
            end else begin
                want = rq.pop_front();
                check("R beat", 64'(cur), 64'(want));
                if (r_first) begin
                    r_d0 = RDATA;
                    r_first = 1'b0;
                end
            end
        end
        stall_prev = RVALID && !RREADY;
        held = cur;
    end

    task automatic do_write(input vec_t v, input int bdelay);
        logic [15:0] a;
        logic        bad;
        int          cnt;
        bq.push_back({v.id, v.exp_bresp});
        @(posedge ACLK); #1;
        AWID = v.id; AWADDR = v.addr; AWLEN = v.len; AWBURST = v.burst; AWVALID = 1'b1;
        cnt = 0;
        @(negedge ACLK);
        while (!AWREADY && cnt < 100) begin @(negedge ACLK); cnt++; end
        if (!AWREADY) fail_timeout("AW handshake");
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
        a = v.addr;
        bad = t_bad(v.len, v.burst);
        for (int i = 0; i <= int'(v.len); i++) begin
            WVALID = 1'b1;
            WDATA  = v.base + 32'(i);
            WSTRB  = v.strb;
            WLAST  = v.bad_wlast ? (i == 0) : (i == int'(v.len));
            cnt = 0;
            @(negedge ACLK);
            while (!WREADY && cnt < 100) begin @(negedge ACLK); cnt++; end
            if (!WREADY) fail_timeout("W handshake");
            if (!bad && int'(a) < DEPTH) begin
                for (int b = 0; b < 4; b++)
                    if (v.strb[b]) model[a[9:0]][8*b +: 8] = WDATA[8*b +: 8];
            end
            a = t_next(a, v.len, v.burst);
            @(posedge ACLK); #1;
        end
        WVALID = 1'b0;
        WLAST  = 1'b0;
        cnt = 0;
        @(negedge ACLK);
        while (!BVALID && cnt < 100) begin @(negedge ACLK); cnt++; end
        if (!BVALID) begin
            fail_timeout("B response");
            void'(bq.pop_front());
        end else begin
            for (int d = 0; d < bdelay; d++) begin
                @(negedge ACLK);
                check("B held", 64'({BVALID, BID, BRESP}), 64'({1'b1, bq[0]}));
            end
            BREADY = 1'b1;
            check("B resp", 64'({BID, BRESP}), 64'(bq.pop_front()));
            @(posedge ACLK); #1;
            BREADY = 1'b0;
        end
        $display("write id=%0h addr=%0h len=%0d burst=%0d bresp=%0d", v.id, v.addr, v.len,
                 v.burst, v.exp_bresp);
    endtask

    task automatic do_read(input vec_t v);
        logic [15:0] a;
        logic        bad;
        rbeat_t      e;
        int          cnt;
        @(posedge ACLK); #1;
        a = v.addr;
        bad = t_bad(v.len, v.burst);
        for (int i = 0; i <= int'(v.len); i++) begin
            e.id   = v.id;
            e.last = (i == int'(v.len));
            if (bad || int'(a) >= DEPTH) begin
                e.resp = 2'b10;
                e.data = '0;
            end else begin
                e.resp = 2'b00;
                e.data = model[a[9:0]];
            end
            rq.push_back(e);
            a = t_next(a, v.len, v.burst);
        end
        r_first = 1'b1;
        ARID = v.id; ARADDR = v.addr; ARLEN = v.len; ARBURST = v.burst; ARVALID = 1'b1;
        cnt = 0;
        @(negedge ACLK);
        while (!ARREADY && cnt < 100) begin @(negedge ACLK); cnt++; end
        if (!ARREADY) fail_timeout("AR handshake");
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
        cnt = 0;
        while (rq.size() != 0 && cnt < 400) begin @(negedge ACLK); cnt++; end
        if (rq.size() != 0) begin
            fail_timeout("R beats");
            rq.delete();
        end
        if (v.chk_d0) check("R first data", 64'(r_d0), 64'(v.exp_d0));
        $display("read  id=%0h addr=%0h len=%0d burst=%0d first=%h", v.id, v.addr, v.len,
                 v.burst, r_d0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(1, 4'h3, 16'd5,    8'd9, INC, 4'hF, 32'd5,        0, 2'b00, 0);
        vecs[1]  = mk(0, 4'h7, 16'd5,    8'd9, INC, 4'hF, 0,            0, 2'b00, 32'd5);
        vecs[2]  = mk(1, 4'h1, 16'h0E,   8'd3, WRP, 4'hF, 32'hA,        0, 2'b00, 0);
        vecs[3]  = mk(0, 4'h2, 16'h0C,   8'd3, INC, 4'hF, 0,            0, 2'b00, 32'hC);
        vecs[4]  = mk(1, 4'h4, 16'h0C,   8'd2, WRP, 4'hF, 32'h50,       0, 2'b10, 0);
        vecs[5]  = mk(0, 4'h2, 16'h0C,   8'd3, INC, 4'hF, 0,            0, 2'b00, 32'hC);
        vecs[6]  = mk(1, 4'h5, 16'd20,   8'd0, INC, 4'hF, 32'hFFFFFFFF, 0, 2'b00, 0);
        vecs[7]  = mk(1, 4'h5, 16'd20,   8'd0, INC, 4'h5, 32'h12345678, 0, 2'b00, 0);
        vecs[8]  = mk(0, 4'h5, 16'd20,   8'd0, INC, 4'hF, 0,            0, 2'b00, 32'hFF34FF78);
        vecs[9]  = mk(1, 4'h6, 16'd1022, 8'd3, INC, 4'hF, 32'h100,      0, 2'b10, 0);
        vecs[10] = mk(0, 4'h6, 16'd1022, 8'd3, INC, 4'hF, 0,            0, 2'b00, 32'h100);
        vecs[11] = mk(1, 4'h9, 16'd40,   8'd3, FIX, 4'hF, 32'h200,      0, 2'b00, 0);
        vecs[12] = mk(0, 4'h9, 16'd40,   8'd2, FIX, 4'hF, 0,            0, 2'b00, 32'h203);
        vecs[13] = mk(0, 4'hA, 16'd5,    8'd1, RSV, 4'hF, 0,            0, 2'b00, 32'h0);
        vecs[14] = mk(1, 4'hB, 16'd5,    8'd1, RSV, 4'hF, 32'h999,      0, 2'b10, 0);
        vecs[15] = mk(0, 4'hB, 16'd5,    8'd1, INC, 4'hF, 0,            0, 2'b00, 32'd5);
        vecs[16] = mk(1, 4'hC, 16'h23,   8'd7, WRP, 4'hF, 32'h300,      0, 2'b00, 0);
        vecs[17] = mk(0, 4'hC, 16'h20,   8'd7, INC, 4'hF, 0,            0, 2'b00, 32'h305);
        vecs[18] = mk(1, 4'hD, 16'd70,   8'd1, INC, 4'hF, 32'h400,      1, 2'b10, 0);
        vecs[19] = mk(0, 4'hD, 16'd70,   8'd1, INC, 4'hF, 0,            0, 2'b00, 32'h400);

        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check("reset outputs", 64'({AWREADY, WREADY, BVALID, BID, BRESP, ARREADY, RVALID, RID,
                                    RDATA, RRESP, RLAST}), 64'(0));
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        @(negedge ACLK);
        check("ready after reset", 64'({AWREADY, ARREADY}), 64'(2'b11));

        for (int i = 0; i < 20; i++) begin
            if (vecs[i].is_wr) do_write(vecs[i], 0);
            else               do_read(vecs[i]);
        end

        // Read backpressure with RREADY 1,0,0,... and a late BREADY.
        rr_mode = 1'b1;
        do_read(mk(0, 4'h7, 16'd5, 8'd3, INC, 4'hF, 0, 0, 2'b00, 32'd5));
        rr_mode = 1'b0;
        do_write(mk(1, 4'h3, 16'd100, 8'd1, INC, 4'hF, 32'h500, 0, 2'b00, 0), 5);
        do_read(mk(0, 4'h3, 16'd100, 8'd1, INC, 4'hF, 0, 0, 2'b00, 32'h500));

        // Reset after beat 2 of a 4-beat write: burst aborted, no B ever.
        @(posedge ACLK); #1;
        AWID = 4'hE; AWADDR = 16'd80; AWLEN = 8'd3; AWBURST = INC; AWVALID = 1'b1;
        @(negedge ACLK);
        check("AW ready pre-abort", 64'(AWREADY), 64'(1));
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
        for (int i = 0; i < 2; i++) begin
            WVALID = 1'b1; WDATA = 32'h600 + 32'(i); WSTRB = 4'hF; WLAST = 1'b0;
            @(negedge ACLK);
            check("W ready pre-abort", 64'(WREADY), 64'(1));
            model[80 + i] = WDATA;
            @(posedge ACLK); #1;
        end
        WVALID = 1'b0;
        ARESETn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            check("in reset", 64'({AWREADY, WREADY, BVALID}), 64'(0));
            if (i < 2) begin @(posedge ACLK); #1; end
        end
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        @(negedge ACLK);
        check("AW ready after release", 64'({AWREADY, WREADY}), 64'(2'b10));
        for (int i = 0; i < 4; i++) begin
            @(negedge ACLK);
            check("no B after abort", 64'(BVALID), 64'(0));
        end
        $display("reset mid-burst sequence done");
        do_read(mk(0, 4'h1, 16'd80, 8'd1, INC, 4'hF, 0, 0, 2'b00, 32'h600));

        // RAM_EN low: requests held but never accepted.
        @(posedge ACLK); #1;
        RAM_EN = 1'b0;
        AWVALID = 1'b1; AWADDR = 16'd5; AWLEN = 8'd0; AWBURST = INC;
        ARVALID = 1'b1; ARADDR = 16'd5; ARLEN = 8'd0; ARBURST = INC;
        for (int i = 0; i < 6; i++) begin
            @(negedge ACLK);
            check("RAM_EN gate", 64'({AWREADY, ARREADY, WREADY, RVALID}), 64'(0));
        end
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
        ARVALID = 1'b0;
        RAM_EN = 1'b1;
        $display("RAM_EN gating sequence done");
        do_read(mk(0, 4'h2, 16'd5, 8'd0, INC, 4'hF, 0, 0, 2'b00, 32'd5));

        repeat (3) @(posedge ACLK);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
